// File: rtl/game_control_if.sv
// Datapath/renderer bundle for game_control: datapath flags in, load strobes and
// ALU select out, plus the draw_req/draw_done handshake.
interface game_control_if;
    logic [1:0] alu_select;
    logic       alu_op;
    logic       ld_alu_out;
    logic       ld_x;
    logic       ld_a;
    logic       ld_b;
    logic       ld_c;
    logic       ld_r;
    logic       ld_jump;
    logic       ld_wall_reset;
    logic       draw_req;
    logic       draw_done;
    logic       wall_wrap;
    logic       collide;
    logic       wall_passed;

    modport master (
        output alu_select, alu_op, ld_alu_out, ld_x, ld_a, ld_b, ld_c, ld_r, ld_jump,
               ld_wall_reset, draw_req,
        input  draw_done, wall_wrap, collide, wall_passed
    );

    modport slave (
        input  alu_select, alu_op, ld_alu_out, ld_x, ld_a, ld_b, ld_c, ld_r, ld_jump,
               ld_wall_reset, draw_req,
        output draw_done, wall_wrap, collide, wall_passed
    );
endinterface

// File: rtl/game_control.sv
// Control FSM for the bird/wall game: one physics step per STEP_DIV frame ticks, then a
// renderer handshake. Define SCORE_EN to build the saturating score counter.
module game_control #(
    parameter int unsigned STEP_DIV = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           jump,
    input  logic           frame_tick,
    output logic [7:0]     score,
    output logic           game_over,
    game_control_if.master bus
);

    typedef enum logic [3:0] {
        StIdle, StInit, StWait, StWall, StVy, StY, StCheck, StDraw, StOver
    } state_e;

    localparam logic [7:0] DivLast = 8'(STEP_DIV - 1);

    state_e     state_q;
    logic [7:0] div_q;
    logic       jump_q;
    logic       jump_pending_q;
    logic [1:0] alu_select_q;
    logic       ld_alu_out_q, ld_x_q, ld_b_q, ld_c_q, ld_r_q, ld_jump_q, ld_wall_reset_q;
    logic       draw_req_q, game_over_q;
    logic       jump_edge;

    assign jump_edge = jump & ~jump_q;

    // Outputs are registered: each transition loads the strobes of the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            div_q           <= 8'd0;
            jump_q          <= 1'b0;
            jump_pending_q  <= 1'b0;
            alu_select_q    <= 2'd0;
            ld_alu_out_q    <= 1'b0;
            ld_x_q          <= 1'b0;
            ld_b_q          <= 1'b0;
            ld_c_q          <= 1'b0;
            ld_r_q          <= 1'b0;
            ld_jump_q       <= 1'b0;
            ld_wall_reset_q <= 1'b0;
            draw_req_q      <= 1'b0;
            game_over_q     <= 1'b0;
        end else begin
            jump_q          <= jump;
            alu_select_q    <= 2'd0;
            ld_alu_out_q    <= 1'b0;
            ld_x_q          <= 1'b0;
            ld_b_q          <= 1'b0;
            ld_c_q          <= 1'b0;
            ld_r_q          <= 1'b0;
            ld_jump_q       <= 1'b0;
            ld_wall_reset_q <= 1'b0;
            draw_req_q      <= 1'b0;
            game_over_q     <= 1'b0;

            // An edge during the S_VY cycle is absorbed by the jump just consumed.
            if (jump_edge && !(state_q inside {StIdle, StOver, StVy})) begin
                jump_pending_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q        <= StInit;
                        ld_r_q         <= 1'b1;
                        div_q          <= 8'd0;
                        jump_pending_q <= 1'b0;
                    end
                end
                StInit: state_q <= StWait;
                StWait: begin
                    if (frame_tick) begin
                        if (div_q == DivLast) begin
                            div_q   <= 8'd0;
                            state_q <= StWall;
                            if (bus.wall_wrap) begin
                                ld_wall_reset_q <= 1'b1;
                            end else begin
                                ld_x_q       <= 1'b1;
                                ld_alu_out_q <= 1'b1;
                            end
                        end else begin
                            div_q <= div_q + 8'd1;
                        end
                    end
                end
                StWall: begin
                    state_q        <= StVy;
                    alu_select_q   <= 2'd1;
                    jump_pending_q <= 1'b0;
                    if (jump_pending_q || jump_edge) begin
                        ld_jump_q <= 1'b1;
                    end else begin
                        ld_b_q       <= 1'b1;
                        ld_alu_out_q <= 1'b1;
                    end
                end
                StVy: begin
                    state_q      <= StY;
                    alu_select_q <= 2'd2;
                    ld_c_q       <= 1'b1;
                    ld_alu_out_q <= 1'b1;
                end
                StY: state_q <= StCheck;
                StCheck: begin
                    if (bus.collide) begin
                        state_q     <= StOver;
                        game_over_q <= 1'b1;
                    end else begin
                        state_q    <= StDraw;
                        draw_req_q <= 1'b1;
                    end
                end
                StDraw: begin
                    if (bus.draw_done) begin
                        state_q <= StWait;
                    end else begin
                        draw_req_q <= 1'b1;
                    end
                end
                StOver: begin
                    if (start) begin
                        state_q        <= StInit;
                        ld_r_q         <= 1'b1;
                        div_q          <= 8'd0;
                        jump_pending_q <= 1'b0;
                    end else begin
                        game_over_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef SCORE_EN
    logic [7:0] score_q;
    logic       score_clr;
    logic       score_inc;

    assign score_clr = (state_q inside {StIdle, StOver}) && start;
    assign score_inc = (state_q == StCheck) && !bus.collide && bus.wall_passed;

    always_ff @(posedge clk) begin
        if (reset || score_clr) begin
            score_q <= 8'd0;
        end else if (score_inc && (score_q != 8'hFF)) begin
            score_q <= score_q + 8'd1;
        end
    end

    assign score = score_q;
`else
    logic unused_wall_passed;
    assign unused_wall_passed = bus.wall_passed;
    assign score = 8'd0;
`endif

    assign bus.alu_select    = alu_select_q;
    assign bus.alu_op        = 1'b0;
    assign bus.ld_alu_out    = ld_alu_out_q;
    assign bus.ld_x          = ld_x_q;
    assign bus.ld_a          = 1'b0;
    assign bus.ld_b          = ld_b_q;
    assign bus.ld_c          = ld_c_q;
    assign bus.ld_r          = ld_r_q;
    assign bus.ld_jump       = ld_jump_q;
    assign bus.ld_wall_reset = ld_wall_reset_q;
    assign bus.draw_req      = draw_req_q;
    assign game_over         = game_over_q;

endmodule

// File: tb/tb_game_control.sv
// Self-checking bench for game_control: randomized steps compared against a step-level
// model of the game rules (tick count, pending jump, saturating score).
module tb_game_control;
    localparam int unsigned STEP_DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       jump = 1'b0;
    logic       frame_tick = 1'b0;
    logic [7:0] score;
    logic       game_over;

    game_control_if bus ();

    game_control #(.STEP_DIV(STEP_DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .jump      (jump),
        .frame_tick(frame_tick),
        .score     (score),
        .game_over (game_over),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int m_score = 0;
    bit m_pending = 1'b0;

    logic [12:0] obs_v;
    assign obs_v = {bus.alu_select, bus.alu_op, bus.ld_alu_out, bus.ld_x, bus.ld_a, bus.ld_b,
                    bus.ld_c, bus.ld_r, bus.ld_jump, bus.ld_wall_reset, bus.draw_req, game_over};

    // Expected output vector; alu_op and ld_a are always 0.
    function automatic logic [12:0] ov(input logic [1:0] sel, input bit alu_out, input bit x,
                                       input bit b, input bit c, input bit r, input bit jmp,
                                       input bit wrst, input bit dreq, input bit gover);
        return {sel, 1'b0, alu_out, x, 1'b0, b, c, r, jmp, wrst, dreq, gover};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int next_score(input int s, input bit passed);
`ifdef SCORE_EN
        return (passed && s < 255) ? s + 1 : s;
`else
        return 0;
`endif
    endfunction

    task automatic run_step(input int n_jumps, input bit jump_in_vy, input bit wrap,
                            input bit passed, input bit coll, input int hold, input int rst_at);
        bus.wall_wrap   = wrap;
        bus.wall_passed = passed;
        bus.collide     = coll;
        for (int j = 0; j < n_jumps; j++) begin
            jump = 1'b1;
            cyc();
            chk("wait_jump_hi", obs_v, 13'd0);
            jump = 1'b0;
            cyc();
            chk("wait_jump_lo", obs_v, 13'd0);
            m_pending = 1'b1;
        end
        for (int k = 0; k < STEP_DIV; k++) begin
            int gap;
            gap = $urandom_range(3, 1);
            repeat (gap) begin
                cyc();
                chk("wait_gap", obs_v, 13'd0);
            end
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
            if (k != STEP_DIV - 1) chk("wait_tick", obs_v, 13'd0);
        end
        chk("wall", obs_v, ov(2'd0, !wrap, !wrap, 0, 0, 0, 0, wrap, 0, 0));
        cyc();
        chk("vy", obs_v, ov(2'd1, !m_pending, 0, !m_pending, 0, 0, m_pending, 0, 0, 0));
        m_pending = 1'b0;
        if (jump_in_vy) jump = 1'b1;
        cyc();
        jump = 1'b0;
        chk("y", obs_v, ov(2'd2, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        cyc();
        chk("check", obs_v, 13'd0);
        if (hold == 0 && !coll) bus.draw_done = 1'b1;
        cyc();
        if (coll) begin
            chk("over_enter", obs_v, ov(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
            chk("score_over", {24'd0, score}, m_score);
            return;
        end
        m_score = next_score(m_score, passed);
        chk("draw_enter", obs_v, ov(2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        chk("score", {24'd0, score}, m_score);
        for (int h = 0; h < hold; h++) begin
            if (h == rst_at) begin
                reset = 1'b1;
                cyc();
                reset = 1'b0;
                chk("rst_draw", obs_v, 13'd0);
                chk("rst_score", {24'd0, score}, 0);
                m_score   = 0;
                m_pending = 1'b0;
                return;
            end
            frame_tick = (h % 4 == 0);
            cyc();
            frame_tick = 1'b0;
            chk("draw_hold", obs_v, ov(2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        end
        bus.draw_done = 1'b1;
        cyc();
        bus.draw_done = 1'b0;
        chk("draw_exit", obs_v, 13'd0);
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("init_ld_r", obs_v, ov(2'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        cyc();
        chk("init_done", obs_v, 13'd0);
        chk("init_score", {24'd0, score}, 0);
        m_score   = 0;
        m_pending = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.draw_done   = 1'b0;
        bus.wall_wrap   = 1'b0;
        bus.collide     = 1'b0;
        bus.wall_passed = 1'b0;

        repeat (3) cyc();
        reset = 1'b0;
        repeat (10) begin
            cyc();
            chk("idle", obs_v, 13'd0);
            chk("idle_score", {24'd0, score}, 0);
        end
        do_start();

        // Directed steps: plain, jump then plain, double jump plus absorbed VY edge, wrap,
        // draw_done already high, long hold with ignored ticks.
        run_step(0, 0, 0, 0, 0, 2, -1);
        run_step(1, 0, 0, 1, 0, 1, -1);
        run_step(0, 0, 0, 0, 0, 1, -1);
        run_step(2, 1, 0, 1, 0, 1, -1);
        run_step(0, 0, 0, 0, 0, 1, -1);
        run_step(0, 0, 1, 0, 0, 1, -1);
        run_step(0, 0, 0, 1, 0, 0, -1);
        run_step(0, 0, 0, 0, 0, 20, -1);
        run_step(0, 0, 0, 0, 0, 1, -1);

        for (int i = 0; i < 40; i++) begin
            int nj;
            nj = $urandom_range(2, 0);
            run_step(nj, (nj > 0) && ($urandom_range(1, 0) == 1), $urandom_range(1, 0) == 1,
                     $urandom_range(1, 0) == 1, 0, $urandom_range(3, 0), -1);
        end

        for (int i = 0; i < 260; i++) begin
            run_step(0, 0, $urandom_range(1, 0) == 1, 1, 0, 0, -1);
        end
`ifdef SCORE_EN
        chk("score_sat", {24'd0, score}, 255);
`else
        chk("score_off", {24'd0, score}, 0);
`endif

        // Collision with wall_passed also high: score must not move.
        run_step(0, 0, 0, 1, 1, 0, -1);
        bus.collide = 1'b0;
        jump = 1'b1;
        cyc();
        chk("over_hold", obs_v, ov(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        jump = 1'b0;
        cyc();
        chk("over_hold2", obs_v, ov(2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        do_start();
        run_step(0, 0, 0, 1, 0, 1, -1);

        // Reset in the middle of a held draw handshake.
        run_step(0, 0, 0, 0, 0, 20, 10);
        repeat (3) begin
            cyc();
            chk("post_rst_idle", obs_v, 13'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
